// File: rtl/maple_bus_tx.sv
// maple_bus_tx: AXI-Stream to Maple Bus SDCKA/SDCKB encoder (start pattern, phase-alternating bits, end pattern).
module maple_bus_tx #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int CLKS_PER_PHASE     = 50
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tx_tdata,
  input  logic                          s_axis_tx_tstrb,
  input  logic                          s_axis_tx_tlast,
  input  logic                          s_axis_tx_tvalid,
  output logic                          s_axis_tx_tready,
  output logic                          sdcka_o,
  output logic                          sdckb_o,
  output logic                          sdck_oe,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          underrun_err
);
  localparam int PW = $clog2(CLKS_PER_PHASE);
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_PHASE - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [PW-1:0]                 phase_q, phase_d;
  logic [3:0]                    step_q, step_d;
  logic [2:0]                    bit_q, bit_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] sh_q, sh_d;
  logic                          last_q, last_d;
  logic                          uflag_q, uflag_d;
  logic                          a_q, a_d, b_q, b_d, oe_q;
  logic                          ph_end, fetch, dbit;
  logic                          unused_ok;

  assign unused_ok = s_axis_tx_tstrb;
  assign ph_end = phase_q == PH_LAST;
  // Fetch points: last cycle of START, and last cycle of bit 0 of a non-last byte.
  assign fetch = ph_end && ((state_q == S_START && step_q == 4'd9) ||
                 (state_q == S_DATA && step_q[0] && bit_q == 3'd0 && !last_q));
  assign s_axis_tx_tready = fetch && s_axis_tx_tvalid;
  assign underrun_err     = fetch && !s_axis_tx_tvalid;
  assign frame_done       = ph_end && state_q == S_END && step_q == 4'd5 && !uflag_q;
  assign sdcka_o = a_q;
  assign sdckb_o = b_q;
  assign sdck_oe = oe_q;
  assign busy    = oe_q;

  always_comb begin
    state_d = state_q;
    phase_d = (state_q == S_IDLE || ph_end) ? '0 : phase_q + 1'b1;
    step_d  = step_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    last_d  = last_q;
    uflag_d = uflag_q;
    if (fetch) begin
      state_d = s_axis_tx_tvalid ? S_DATA : S_END;
      step_d  = 4'd0;
      bit_d   = 3'd7;
      sh_d    = s_axis_tx_tvalid ? s_axis_tx_tdata : sh_q;
      last_d  = s_axis_tx_tvalid ? s_axis_tx_tlast : last_q;
      uflag_d = !s_axis_tx_tvalid;
    end else if (state_q == S_IDLE) begin
      state_d = s_axis_tx_tvalid ? S_START : S_IDLE;
      step_d  = 4'd0;
      uflag_d = 1'b0;
    end else if (ph_end) begin
      if (state_q == S_START) begin
        step_d = step_q + 4'd1;
      end else if (state_q == S_DATA) begin
        if (!step_q[0]) begin
          step_d = 4'd1;
        end else if (bit_q == 3'd0) begin
          state_d = S_END;
          step_d  = 4'd0;
        end else begin
          step_d = 4'd0;
          bit_d  = bit_q - 3'd1;
          sh_d   = sh_q << 1;
        end
      end else if (step_q == 4'd5) begin
        state_d = S_IDLE;
        step_d  = 4'd0;
      end else begin
        step_d = step_q + 4'd1;
      end
    end
  end

  // Line levels are decoded from the next state so the pins themselves are registered.
  always_comb begin
    dbit = sh_d[C_AXIS_TDATA_WIDTH-1];
    a_d = state_d == S_START ? step_d == 4'd9 :
          state_d == S_DATA  ? (bit_d[0] ? !step_d[0] : dbit) :
          state_d == S_END   ? (!step_d[0] || step_d == 4'd5) : 1'b1;
    b_d = state_d == S_START ? (!step_d[0] || step_d == 4'd9) :
          state_d == S_DATA  ? (bit_d[0] ? dbit : !step_d[0]) :
          state_d == S_END   ? step_d == 4'd5 : 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      step_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      uflag_q <= 1'b0;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      uflag_q <= uflag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      oe_q    <= state_d != S_IDLE;
    end
  end
endmodule

// File: tb/tb_maple_bus_tx.sv
// tb_maple_bus_tx: directed checks of the Maple Bus transmitter with a trace-based loopback decoder.
module tb_maple_bus_tx;
  localparam int P = 4;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [7:0] s_axis_tx_tdata = 8'h00;
  logic s_axis_tx_tstrb = 1'b0;
  logic s_axis_tx_tlast = 1'b0;
  logic s_axis_tx_tvalid = 1'b0;
  logic s_axis_tx_tready, sdcka_o, sdckb_o, sdck_oe, busy, frame_done, underrun_err;

  always #5 aclk = ~aclk;

  maple_bus_tx #(.C_AXIS_TDATA_WIDTH(8), .CLKS_PER_PHASE(P)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tstrb(s_axis_tx_tstrb),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .s_axis_tx_tready(s_axis_tx_tready), .sdcka_o(sdcka_o), .sdckb_o(sdckb_o),
    .sdck_oe(sdck_oe), .busy(busy), .frame_done(frame_done), .underrun_err(underrun_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0, rel = 0, len = 0, gap = 0, idle_run = 0, start_cyc = 0;
  int n_rdy = 0, n_fd = 0, n_ur = 0, ur_cyc = 0, viol = 0;
  int rdy_c[0:15];
  logic rec_a[0:511];
  logic rec_b[0:511];
  logic oe_p = 1'b0, a_p = 1'b1, b_p = 1'b1;
  logic [7:0] tx_d[0:7];
  logic tx_l[0:7];
  int fd0, ur0, r0;

  // Bus trace: every oe-high cycle is recorded, indexed from START entry.
  always @(negedge aclk) begin
    cyc <= cyc + 1;
    oe_p <= sdck_oe;
    a_p <= sdcka_o;
    b_p <= sdckb_o;
    idle_run <= sdck_oe ? 0 : idle_run + 1;
    if (sdck_oe && !oe_p) begin
      rel <= 1;
      start_cyc <= cyc;
      gap <= idle_run;
      rec_a[0] <= sdcka_o;
      rec_b[0] <= sdckb_o;
    end else if (sdck_oe) begin
      rel <= rel + 1;
      if (rel < 512) begin
        rec_a[rel] <= sdcka_o;
        rec_b[rel] <= sdckb_o;
      end
    end
    if (!sdck_oe && oe_p) len <= rel;
    if (s_axis_tx_tready) begin
      n_rdy <= n_rdy + 1;
      rdy_c[n_rdy % 16] <= cyc;
    end
    if (frame_done) n_fd <= n_fd + 1;
    if (underrun_err) begin
      n_ur <= n_ur + 1;
      ur_cyc <= cyc;
    end
    if (sdck_oe && oe_p && (((a_p && !sdcka_o) && (sdckb_o != b_p)) ||
                            ((b_p && !sdckb_o) && (sdcka_o != a_p)))) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int a_low_run();
    int i = 0;
    while (i < 512 && rec_a[i] === 1'b0) i++;
    return i;
  endfunction

  function automatic int falls(input bit on_a, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (on_a ? (rec_a[i-1] && !rec_a[i]) : (rec_b[i-1] && !rec_b[i])) n++;
    return n;
  endfunction

  task automatic check_byte(input string tag, input int k, input logic [7:0] exp);
    logic [7:0] v;
    int ok;
    int t;
    ok = 1;
    v = 8'h00;
    for (int j = 0; j < 8; j++) begin
      t = 10*P + 16*P*k + 2*P*j + P;
      if (j % 2 == 0) begin
        if (!(rec_a[t-1] && !rec_a[t])) ok = 0;
        v[7-j] = rec_b[t];
      end else begin
        if (!(rec_b[t-1] && !rec_b[t])) ok = 0;
        v[7-j] = rec_a[t];
      end
    end
    chk(tag, {24'h0, v}, {24'h0, exp});
    chk({tag, "_clk"}, ok, 1);
  endtask

  task automatic feed(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      s_axis_tx_tdata = tx_d[i];
      s_axis_tx_tlast = tx_l[i];
      s_axis_tx_tvalid = 1'b1;
      k = 0;
      @(negedge aclk);
      while (!s_axis_tx_tready && k < 4000) begin
        @(negedge aclk);
        k++;
      end
      chk("ready", s_axis_tx_tready, 1);
      @(posedge aclk);
      #1;
    end
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 4000) begin
      @(negedge aclk);
      k++;
    end
    chk("idle", busy, 0);
    repeat (2) @(negedge aclk);
  endtask

  task automatic snap();
    fd0 = n_fd;
    ur0 = n_ur;
    r0 = n_rdy;
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    chk("rst_oe", sdck_oe, 0);
    chk("rst_ab", {sdcka_o, sdckb_o}, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {s_axis_tx_tready, frame_done, underrun_err}, 3'b000);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("idle_oe", sdck_oe, 0);

    // 1: single byte 0xA5
    snap();
    tx_d[0] = 8'hA5; tx_l[0] = 1'b1;
    feed(1);
    wait_idle();
    chk("t1_a_low", a_low_run(), 9*P);
    chk("t1_b_pulses", falls(0, 1, 10*P-1), 4);
    check_byte("t1_byte", 0, 8'hA5);
    chk("t1_len", len, 32*P);
    chk("t1_done", n_fd - fd0, 1);
    chk("t1_ur", n_ur - ur0, 0);
    chk("t1_rdy", n_rdy - r0, 1);
    chk("t1_fetch_at", rdy_c[r0 % 16] - start_cyc, 10*P-1);
    chk("t1_end_first", {rec_a[26*P], rec_b[26*P]}, 2'b10);
    chk("t1_end_afalls", falls(1, 26*P+1, 32*P-1), 2);
    chk("t1_end_last", {rec_a[32*P-1], rec_b[32*P-1]}, 2'b11);

    // 2: five bytes, tvalid held
    snap();
    for (int i = 0; i < 5; i++) begin
      tx_d[i] = 8'(i);
      tx_l[i] = (i == 4);
    end
    feed(5);
    wait_idle();
    chk("t2_rdy", n_rdy - r0, 5);
    for (int i = 0; i < 4; i++) chk("t2_spacing", rdy_c[(r0+i+1) % 16] - rdy_c[(r0+i) % 16], 16*P);
    for (int i = 0; i < 5; i++) check_byte("t2_byte", i, 8'(i));
    chk("t2_len", len, 96*P);
    chk("t2_done", n_fd - fd0, 1);

    // 3: underrun at the third fetch
    snap();
    tx_d[0] = 8'h3C; tx_l[0] = 1'b0;
    tx_d[1] = 8'hC3; tx_l[1] = 1'b0;
    feed(2);
    wait_idle();
    chk("t3_rdy", n_rdy - r0, 2);
    chk("t3_ur", n_ur - ur0, 1);
    chk("t3_ur_at", ur_cyc - start_cyc, 42*P-1);
    chk("t3_done", n_fd - fd0, 0);
    chk("t3_len", len, 48*P);
    chk("t3_end_first", {rec_a[42*P], rec_b[42*P]}, 2'b10);
    check_byte("t3_b0", 0, 8'h3C);
    check_byte("t3_b1", 1, 8'hC3);

    // 4: reset in the middle of DATA, then a clean frame
    snap();
    tx_d[0] = 8'hFF; tx_l[0] = 1'b1;
    feed(1);
    repeat (30) @(negedge aclk);
    chk("t4_in_frame", sdck_oe, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("t4_rst_oe", sdck_oe, 0);
    chk("t4_rst_ab", {sdcka_o, sdckb_o}, 2'b11);
    chk("t4_rst_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("t4_no_done", n_fd - fd0, 0);
    tx_d[0] = 8'h5A; tx_l[0] = 1'b1;
    feed(1);
    wait_idle();
    chk("t4_a_low", a_low_run(), 9*P);
    chk("t4_b_pulses", falls(0, 1, 10*P-1), 4);
    check_byte("t4_byte", 0, 8'h5A);
    chk("t4_len", len, 32*P);
    chk("t4_done", n_fd - fd0, 1);

    // 5: back-to-back single-byte frames
    snap();
    tx_d[0] = 8'h81; tx_l[0] = 1'b1;
    tx_d[1] = 8'h7E; tx_l[1] = 1'b1;
    feed(2);
    wait_idle();
    chk("t5_gap", gap, 1);
    chk("t5_spacing", rdy_c[(r0+1) % 16] - rdy_c[r0 % 16], 32*P+1);
    check_byte("t5_byte", 0, 8'h7E);
    chk("t5_len", len, 32*P);
    chk("t5_done", n_fd - fd0, 2);

    chk("no_double_change", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
